div_seq_32: RTL and testbench

DIV_SEQ_32 -- requirements
Module: div_seq_32

---
 rtl/alu_pkg.sv | 16 +
 rtl/add_sub_33.sv | 20 ++
 rtl/div_seq_32.sv | 135 +++++++++++++
 tb/tb_div_seq_32.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential divider.
//   DIV_WIDTH   : default operand/result width
//   DIV_LATENCY : start edge to result-valid, in clock cycles
//   div_state_t : divider control states
package alu_pkg;

    localparam int unsigned DIV_WIDTH   = 32;
    localparam int unsigned DIV_LATENCY = DIV_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/add_sub_33.sv
// Trial subtractor for the restoring divider step.
//   a    : shifted partial remainder (W bits)
//   b    : divisor magnitude, zero-extended (W bits)
//   diff : a - b
//   neg  : sign bit of the difference (1 = trial failed)
module add_sub_33 #(
    parameter int unsigned W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         neg
);

    always_comb begin
        diff = a - b;
        neg  = diff[W-1];
    end

endmodule

// File: rtl/div_seq_32.sv
// Sequential signed restoring divider, one quotient bit per clock.
//   clock, resetn   : rising-edge clock, async active-low reset
//   ctrl_div        : start pulse; samples operands, aborts any running division
//   data_dividend   : signed dividend
//   data_divisor    : signed divisor
//   data_quotient   : signed quotient, truncated toward zero
//   data_remainder  : signed remainder, sign of the dividend
//   data_exception  : divide-by-zero flag
//   data_resultRDY  : one-cycle pulse, WIDTH+1 cycles after the start edge
//   busy            : high while in RUN or DONE
module div_seq_32
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_dividend,
    input  logic [WIDTH-1:0] data_divisor,
    output logic [WIDTH-1:0] data_quotient,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int unsigned   CW        = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    div_state_t state, state_nxt;

    logic [CW-1:0]    step_cnt;
    // {remainder[WIDTH:0], quotient[WIDTH-1:0]} as a single shift register
    logic [2*WIDTH:0] acc;
    logic [WIDTH-1:0] dvsr_mag;
    logic             q_neg;
    logic             r_neg;
    logic             dvsr_zero;

    logic [WIDTH-1:0] dvnd_mag_in;
    logic [WIDTH-1:0] dvsr_mag_in;
    logic [WIDTH:0]   trial_a;
    logic [WIDTH:0]   trial_diff;
    logic             trial_neg;
    logic             q_bit;
    logic [WIDTH-1:0] quo_mag;
    logic [WIDTH-1:0] rem_mag;

    always_comb begin
        dvnd_mag_in = data_dividend[WIDTH-1] ? -data_dividend : data_dividend;
        dvsr_mag_in = data_divisor[WIDTH-1]  ? -data_divisor  : data_divisor;
        // remainder part of acc after the 1-bit left shift
        trial_a     = acc[2*WIDTH-1:WIDTH-1];
        // a set remainder MSB would be shifted out: the true shifted value
        // then exceeds any divisor, so the trial succeeds
        q_bit       = acc[2*WIDTH] | ~trial_neg;
        quo_mag     = acc[WIDTH-1:0];
        rem_mag     = acc[2*WIDTH-1:WIDTH];
    end

    add_sub_33 #(
        .W(WIDTH + 1)
    ) u_sub (
        .a    (trial_a),
        .b    ({1'b0, dvsr_mag}),
        .diff (trial_diff),
        .neg  (trial_neg)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (ctrl_div) begin
            state_nxt = RUN;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                RUN:     state_nxt = (step_cnt == LAST_STEP) ? DONE : RUN;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            step_cnt       <= '0;
            acc            <= '0;
            dvsr_mag       <= '0;
            q_neg          <= 1'b0;
            r_neg          <= 1'b0;
            dvsr_zero      <= 1'b0;
            data_quotient  <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= (state == DONE);

            // results are registered out of DONE; a restart in the same
            // cycle still sees the finished acc (non-blocking update)
            if (state == DONE) begin
                // with a zero divisor every trial succeeds, so the remainder
                // ends up holding |dividend|; only the quotient needs forcing
                data_quotient  <= dvsr_zero ? '0 : (q_neg ? -quo_mag : quo_mag);
                data_remainder <= r_neg ? -rem_mag : rem_mag;
                data_exception <= dvsr_zero;
            end

            if (ctrl_div) begin
                acc       <= {{(WIDTH + 1){1'b0}}, dvnd_mag_in};
                dvsr_mag  <= dvsr_mag_in;
                q_neg     <= data_dividend[WIDTH-1] ^ data_divisor[WIDTH-1];
                r_neg     <= data_dividend[WIDTH-1];
                dvsr_zero <= (data_divisor == '0);
                step_cnt  <= '0;
            end else if (state == RUN) begin
                acc      <= q_bit ? {trial_diff, acc[WIDTH-2:0], 1'b1}
                                  : {acc[2*WIDTH-1:0], 1'b0};
                step_cnt <= step_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_div_seq_32.sv
module tb_div_seq_32;
    import alu_pkg::*;

    localparam int unsigned W = DIV_WIDTH;

    logic         clock = 1'b0;
    logic         resetn = 1'b0;
    logic         ctrl_div = 1'b0;
    logic [W-1:0] data_dividend = '0;
    logic [W-1:0] data_divisor = '0;
    logic [W-1:0] data_quotient;
    logic [W-1:0] data_remainder;
    logic         data_exception;
    logic         data_resultRDY;
    logic         busy;

    always #5 clock = ~clock;

    div_seq_32 #(
        .WIDTH(W)
    ) dut (
        .clock          (clock),
        .resetn         (resetn),
        .ctrl_div       (ctrl_div),
        .data_dividend  (data_dividend),
        .data_divisor   (data_divisor),
        .data_quotient  (data_quotient),
        .data_remainder (data_remainder),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         exc;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa, sb, qq, rr;
        if (b == '0) begin
            e.q = '0;
            e.r = a;
            e.exc = 1'b1;
        end else begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
            qq = sa / sb;
            rr = sa - qq * sb;
            e.q = qq[W-1:0];
            e.r = rr[W-1:0];
            e.exc = 1'b0;
        end
        return e;
    endfunction

    task automatic start_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        ctrl_div = 1'b1;
        data_dividend = a;
        data_divisor = b;
        @(posedge clock);
        #1;
        ctrl_div = 1'b0;
        if (push) exp_q.push_back(model(a, b));
    endtask

    task automatic wait_rdy(input int limit, output int cycles);
        cycles = -1;
        for (int c = 1; c <= limit; c++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                cycles = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int   cyc;
        exp_t e;
        logic [2*W:0] got;
        resetn = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_vec++;
        if ({data_quotient, data_remainder, data_exception, data_resultRDY, busy} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got q=%h r=%h exc=%b rdy=%b busy=%b required all 0",
                     data_quotient, data_remainder, data_exception, data_resultRDY, busy);
        end
        resetn = 1'b1;
        start_div(W'(100), W'(7), 1'b1);
        wait_rdy(40, cyc);
        n_vec++;
        if (cyc != int'(DIV_LATENCY)) begin
            n_bad++;
            $display("FAIL first_start_latency got=%0d required=%0d", cyc, DIV_LATENCY);
        end
        n_vec++;
        got = {data_quotient, data_remainder, data_exception};
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL first_start_result got=%h required=none", got);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                n_bad++;
                $display("FAIL first_start_result got q/r/exc=%h/%h/%b required=%h/%h/%b",
                         data_quotient, data_remainder, data_exception, e.q, e.r, e.exc);
            end
        end
    endtask

    task automatic test_basic();
        int   cyc;
        exp_t e;
        start_div(W'(100), W'(7), 1'b0);
        n_vec++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_in_run got=%b required=1", busy);
        end
        wait_rdy(40, cyc);
        n_vec++;
        if (cyc != 33) begin
            n_bad++;
            $display("FAIL basic_latency got=%0d required=33", cyc);
        end
        e.q = W'(14);
        e.r = W'(2);
        e.exc = 1'b0;
        n_vec++;
        if ({data_quotient, data_remainder, data_exception} !== e) begin
            n_bad++;
            $display("FAIL basic_100_div_7 got q/r/exc=%h/%h/%b required=%h/%h/%b",
                     data_quotient, data_remainder, data_exception, e.q, e.r, e.exc);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            n_vec++;
            if ({data_resultRDY, busy, data_quotient, data_remainder, data_exception} !== {2'b00, e}) begin
                n_bad++;
                $display("FAIL pulse_width_hold got rdy/busy/q/r=%b/%b/%h/%h required 0/0/%h/%h",
                         data_resultRDY, busy, data_quotient, data_remainder, e.q, e.r);
            end
        end
    endtask

    task automatic test_signs();
        logic [W-1:0] va [3];
        logic [W-1:0] vb [3];
        int   cyc;
        exp_t e;
        logic [2*W:0] got;
        va[0] = W'(-100); vb[0] = W'(7);
        va[1] = W'(100);  vb[1] = W'(-7);
        va[2] = W'(-100); vb[2] = W'(-7);
        for (int i = 0; i < 3; i++) begin
            start_div(va[i], vb[i], 1'b1);
            wait_rdy(40, cyc);
            n_vec++;
            if (cyc != 33) begin
                n_bad++;
                $display("FAIL signs_latency[%0d] got=%0d required=33", i, cyc);
            end
            n_vec++;
            got = {data_quotient, data_remainder, data_exception};
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL signs_result[%0d] got=%h required=none", i, got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_bad++;
                    $display("FAIL signs_result[%0d] got q/r/exc=%h/%h/%b required=%h/%h/%b",
                             i, data_quotient, data_remainder, data_exception, e.q, e.r, e.exc);
                end
            end
        end
    endtask

    task automatic test_div_zero();
        logic [W-1:0] va [2];
        int   cyc;
        exp_t e;
        logic [2*W:0] got;
        va[0] = W'(32'h12345678);
        va[1] = W'(32'h80000000);
        for (int i = 0; i < 2; i++) begin
            start_div(va[i], '0, 1'b1);
            wait_rdy(40, cyc);
            n_vec++;
            if (cyc != 33) begin
                n_bad++;
                $display("FAIL div0_latency[%0d] got=%0d required=33", i, cyc);
            end
            n_vec++;
            got = {data_quotient, data_remainder, data_exception};
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL div0_result[%0d] got=%h required=none", i, got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_bad++;
                    $display("FAIL div0_result[%0d] got q/r/exc=%h/%h/%b required=%h/%h/%b",
                             i, data_quotient, data_remainder, data_exception, e.q, e.r, e.exc);
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [W-1:0] vb [2];
        int   cyc;
        exp_t e;
        vb[0] = W'(32'hFFFFFFFF);
        vb[1] = W'(1);
        for (int i = 0; i < 2; i++) begin
            start_div(W'(32'h80000000), vb[i], 1'b1);
            wait_rdy(40, cyc);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
            n_vec++;
            if (cyc != 33 || {data_quotient, data_remainder, data_exception} !== {W'(32'h80000000), W'(0), 1'b0}
                || e.q !== W'(32'h80000000)) begin
                n_bad++;
                $display("FAIL min_int_div[%0d] got cyc/q/r/exc=%0d/%h/%h/%b required=33/80000000/00000000/0",
                         i, cyc, data_quotient, data_remainder, data_exception);
            end
        end
    endtask

    task automatic test_abort();
        int   pulses = 0;
        int   first = -1;
        exp_t e;
        logic [2*W:0] got;
        start_div(W'(50), W'(5), 1'b0);
        repeat (9) begin
            @(posedge clock);
            #1;
        end
        start_div(W'(9), W'(4), 1'b1);
        for (int c = 1; c <= 45; c++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                pulses++;
                if (first < 0) begin
                    first = c;
                    n_vec++;
                    got = {data_quotient, data_remainder, data_exception};
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL abort_result got=%h required=none", got);
                    end else begin
                        e = exp_q.pop_front();
                        if (got !== e || e.q !== W'(2) || e.r !== W'(1)) begin
                            n_bad++;
                            $display("FAIL abort_result got q/r/exc=%h/%h/%b required=%h/%h/%b",
                                     data_quotient, data_remainder, data_exception, e.q, e.r, e.exc);
                        end
                    end
                end
            end
        end
        n_vec++;
        if (pulses != 1 || first != 33) begin
            n_bad++;
            $display("FAIL abort_pulses got count/cycle=%0d/%0d required=1/33", pulses, first);
        end
    endtask

    task automatic test_back_to_back();
        int   cyc;
        exp_t e;
        logic [2*W:0] got;
        start_div(W'(1000), W'(-3), 1'b1);
        repeat (32) begin
            @(posedge clock);
            #1;
        end
        // now in DONE: restart while the first result is emitted
        start_div(W'(-77), W'(6), 1'b1);
        n_vec++;
        got = {data_quotient, data_remainder, data_exception};
        if (data_resultRDY !== 1'b1 || exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL done_restart_pulse got rdy=%b required=1", data_resultRDY);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                n_bad++;
                $display("FAIL done_restart_first got q/r/exc=%h/%h/%b required=%h/%h/%b",
                         data_quotient, data_remainder, data_exception, e.q, e.r, e.exc);
            end
        end
        wait_rdy(40, cyc);
        n_vec++;
        got = {data_quotient, data_remainder, data_exception};
        if (cyc != 33 || exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL done_restart_second got cyc=%0d required=33", cyc);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                n_bad++;
                $display("FAIL done_restart_second got q/r/exc=%h/%h/%b required=%h/%h/%b",
                         data_quotient, data_remainder, data_exception, e.q, e.r, e.exc);
            end
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        start_div(W'(123456), W'(789), 1'b1);
        repeat (20) begin
            @(posedge clock);
            #1;
        end
        resetn = 1'b0;
        #1;
        n_vec++;
        if ({data_quotient, data_remainder, data_exception, data_resultRDY, busy} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_outputs got q=%h r=%h exc=%b rdy=%b busy=%b required all 0",
                     data_quotient, data_remainder, data_exception, data_resultRDY, busy);
        end
        exp_q.delete();
        @(posedge clock);
        #1;
        resetn = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) pulses++;
        end
        n_vec++;
        if (pulses != 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_no_pulse got pulses/busy=%0d/%b required=0/0", pulses, busy);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        int   cyc;
        exp_t e;
        logic [2*W:0] got;
        for (int i = 0; i < 10; i++) begin
            a = W'($urandom);
            b = ($urandom_range(0, 2) == 0) ? W'($urandom_range(1, 20)) : W'($urandom >> $urandom_range(0, 28));
            if ($urandom_range(0, 1) == 1) b = -b;
            start_div(a, b, 1'b1);
            wait_rdy(40, cyc);
            n_vec++;
            got = {data_quotient, data_remainder, data_exception};
            if (cyc != 33 || exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL random[%0d] got cyc=%0d required=33", i, cyc);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_bad++;
                    $display("FAIL random[%0d] %h/%h got q/r/exc=%h/%h/%b required=%h/%h/%b",
                             i, a, b, data_quotient, data_remainder, data_exception, e.q, e.r, e.exc);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_div_zero();
        test_overflow();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
